ahb_mem_bist: RTL and testbench

AHB_MEM_BIST -- requirements
Module: ahb_mem_bist

---
 rtl/ahb_mem_bist.sv | 129 ++++++++++++
 tb/tb_ahb_mem_bist.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ahb_mem_bist.sv
// ahb_mem_bist: AHB-Lite master that writes seed+i to consecutive words, reads them back and counts mismatches.
module ahb_mem_bist #(
    parameter int CNTW = 8
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            start,
    input  logic [31:0]     base_addr,
    input  logic [CNTW-1:0] num_words,
    input  logic [31:0]     seed,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            aborted,
    output logic [CNTW-1:0] err_count,
    output logic [31:0]     first_err_addr,
    output logic [31:0]     HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [31:0]     HWDATA,
    input  logic [31:0]     HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t state;
    logic [31:0] base, sd, rd_exp, rd_adr;
    logic [CNTW-1:0] num, idx, rd_idx, err_nxt;
    logic rd_ph, err_cyc, chk, miss, last;
    assign HSIZE = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT = 4'b0011;
    assign rd_exp = sd + 32'(rd_idx);
    assign rd_adr = base + (32'(rd_idx) << 2);
    assign err_cyc = HRESP && !HREADY && (state == WRITE || state == READ || state == DRAIN);
    assign chk = rd_ph && HREADY && !HRESP;
    assign miss = chk && HRDATA != rd_exp;
    assign err_nxt = (miss && err_count != '1) ? err_count + 1'b1 : err_count;
    assign last = idx == num - 1'b1;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            base <= '0;
            sd <= '0;
            num <= '0;
            idx <= '0;
            rd_idx <= '0;
            rd_ph <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            aborted <= 1'b0;
            err_count <= '0;
            first_err_addr <= '0;
            HADDR <= '0;
            HTRANS <= 2'b00;
            HWRITE <= 1'b0;
            HWDATA <= '0;
        end else begin
            if (chk) rd_ph <= 1'b0;
            if (miss) begin
                err_count <= err_nxt;
                if (err_count == '0) first_err_addr <= rd_adr;
            end
            case (state)
                IDLE: if (start) begin
                    base <= {base_addr[31:2], 2'b00};
                    num <= num_words;
                    sd <= seed;
                    idx <= '0;
                    err_count <= '0;
                    first_err_addr <= '0;
                    aborted <= 1'b0;
                    pass <= num_words == '0;
                    if (num_words == '0) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else begin
                        state <= WRITE;
                        busy <= 1'b1;
                        HTRANS <= 2'b10;
                        HWRITE <= 1'b1;
                        HADDR <= {base_addr[31:2], 2'b00};
                    end
                end
                WRITE, READ: if (err_cyc) begin
                    HTRANS <= 2'b00;
                    aborted <= 1'b1;
                    state <= DRAIN;
                end else if (HREADY) begin
                    if (state == WRITE) HWDATA <= sd + 32'(idx);
                    else begin
                        rd_ph <= 1'b1;
                        rd_idx <= idx;
                    end
                    if (last) begin
                        idx <= '0;
                        HADDR <= base;
                        HWRITE <= 1'b0;
                        if (state == WRITE) state <= READ;
                        else begin
                            state <= DRAIN;
                            HTRANS <= 2'b00;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                        HADDR <= HADDR + 32'd4;
                    end
                end
                DRAIN: if (err_cyc) aborted <= 1'b1;
                else if (HREADY) begin
                    state <= DONE;
                    done <= 1'b1;
                    busy <= 1'b0;
                    rd_ph <= 1'b0;
                    pass <= err_nxt == '0 && !aborted && !HRESP;
                end
                DONE: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_mem_bist.sv
// tb_ahb_mem_bist: acts as the AHB slave and checks every cycle against a transfer-list model of the run.
module tb_ahb_mem_bist;
    localparam int CNTW = 8;
    logic HCLK = 0, HRESETn = 0, start = 0;
    logic [31:0] base_addr = 0, seed = 0, HRDATA = 0;
    logic [CNTW-1:0] num_words = 0;
    logic HREADY = 1, HRESP = 0;
    logic busy, done, pass, aborted, HWRITE;
    logic [CNTW-1:0] err_count;
    logic [31:0] first_err_addr, HADDR, HWDATA;
    logic [1:0] HTRANS;
    logic [2:0] HSIZE, HBURST;
    logic [3:0] HPROT;
    int checks = 0, passed = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 HCLK = ~HCLK;

    ahb_mem_bist #(.CNTW(CNTW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
        .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .aborted(aborted), .err_count(err_count), .first_err_addr(first_err_addr),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", nm, c, act, exp);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, " htrans"}, 32'(HTRANS), 0, -1);
        chk({tag, " busy"}, 32'(busy), 0, -1);
        chk({tag, " done"}, 32'(done), 0, -1);
        chk({tag, " haddr"}, HADDR, 0, -1);
        chk({tag, " hwdata"}, HWDATA, 0, -1);
        chk({tag, " hwrite"}, 32'(HWRITE), 0, -1);
        chk({tag, " pass"}, 32'(pass), 0, -1);
        chk({tag, " aborted"}, 32'(aborted), 0, -1);
        chk({tag, " err_count"}, 32'(err_count), 0, -1);
        chk({tag, " first_err_addr"}, first_err_addr, 0, -1);
        chk({tag, " hsize/hburst/hprot"}, {22'd0, HSIZE, HBURST, HPROT}, {22'd0, 3'b010, 3'b000, 4'b0011}, -1);
    endtask

    // Transfers 0..n-1 are writes, n..2n-1 reads; ap is the transfer in its address phase, dp the one in its data phase.
    task automatic run(input logic [31:0] b, input int n, input logic [31:0] s,
                       input int st_at, input int st_len, input logic [31:0] bad, input int err_at, input int ign,
                       input int done_exp, input int errs_exp, input logic [31:0] fea_exp, input logic pass_exp,
                       input int pin_c, input logic [31:0] pin_a, input logic [31:0] pin_d);
        int ap, dp, errs, c, done_cyc;
        logic ab, rdy, rsp, is_done;
        logic [31:0] ba, a, wd;
        ba = {b[31:2], 2'b00};
        ap = 0; dp = -1; errs = 0; ab = 0; done_cyc = -1; wd = 0;
        a = 0;
        mem.delete();
        @(negedge HCLK);
        base_addr = b; num_words = n[CNTW-1:0]; seed = s; start = 1;
        @(posedge HCLK);
        #1 start = 0;
        c = 1;
        while (c <= 60 && done_cyc < 0) begin
            rdy = !(c >= st_at && c < st_at + st_len);
            rsp = 0;
            if (c == err_at) begin rdy = 0; rsp = 1; end
            if (c == err_at + 1) begin rdy = 1; rsp = 1; end
            HREADY = rdy; HRESP = rsp;
            if (c == ign) begin start = 1; base_addr = 32'hF000; end
            else begin start = 0; base_addr = b; end
            HRDATA = 0;
            if (dp >= n) begin
                a = ba + 32'(4 * (dp - n));
                HRDATA = (a == bad) ? 32'hDEADBEEF : (mem.exists(a) ? mem[a] : 32'h0);
            end
            is_done = ap >= 2 * n && dp < 0;
            chk("htrans", 32'(HTRANS), (ap < 2 * n) ? 2 : 0, c);
            chk("busy", 32'(busy), 32'(!is_done), c);
            chk("done", 32'(done), 32'(is_done), c);
            if (ap < 2 * n) begin
                chk("haddr", HADDR, ba + 32'(4 * (ap % n)), c);
                chk("hwrite", 32'(HWRITE), 32'(ap < n), c);
            end
            if (dp >= 0 && dp < n) chk("hwdata", HWDATA, s + 32'(dp), c);
            if (c == pin_c) begin
                chk("pinned haddr", HADDR, pin_a, c);
                chk("pinned hwdata", HWDATA, pin_d, c);
            end
            if (is_done) begin
                done_cyc = c;
                chk("pass", 32'(pass), 32'(errs == 0 && !ab), c);
                chk("aborted", 32'(aborted), 32'(ab), c);
                chk("err_count", 32'(err_count), 32'(errs), c);
                chk("first_err_addr", first_err_addr, a == a ? first_err_addr_model(errs, ba, bad) : 0, c);
                chk("done cycle", 32'(c), 32'(done_exp), c);
                chk("model errs", 32'(errs), 32'(errs_exp), c);
                chk("err_count literal", 32'(err_count), 32'(errs_exp), c);
                chk("first_err_addr literal", first_err_addr, fea_exp, c);
                chk("pass literal", 32'(pass), 32'(pass_exp), c);
            end
            wd = HWDATA;
            @(posedge HCLK);
            if (rsp && !rdy) begin
                ab = 1;
                ap = 2 * n;
            end else if (rdy) begin
                if (dp >= 0 && dp < n) mem[ba + 32'(4 * dp)] = wd;
                else if (dp >= n && !rsp && HRDATA != s + 32'(dp - n)) errs = (errs < 255) ? errs + 1 : errs;
                dp = (ap < 2 * n) ? ap : -1;
                if (ap < 2 * n) ap++;
            end
            #1 c++;
        end
        HREADY = 1; HRESP = 0; start = 0; base_addr = b;
        if (done_cyc < 0) chk("done timeout", 32'(c), 32'(done_exp), c);
        chk("after done: done", 32'(done), 0, c);
        chk("after done: busy", 32'(busy), 0, c);
        chk("after done: htrans", 32'(HTRANS), 0, c);
        chk("after done: pass held", 32'(pass), 32'(pass_exp), c);
    endtask

    function automatic logic [31:0] first_err_addr_model(input int errs, input logic [31:0] ba, input logic [31:0] bad);
        return (errs > 0) ? bad : 32'h0;
    endfunction

    initial begin
        #2 reset_outputs("in reset");
        @(negedge HCLK);
        HRESETn = 1;
        repeat (3) begin
            @(posedge HCLK);
            #1 chk("idle htrans", 32'(HTRANS), 0, -1);
        end
        run(32'h100, 4, 32'hA5A50000, -1, 0, 32'h1, -10, 3, 10, 0, 32'h0, 1, 5, 32'h100, 32'hA5A50003);
        run(32'h100, 4, 32'hA5A50000, 3, 2, 32'h1, -10, -1, 12, 0, 32'h0, 1, 4, 32'h108, 32'hA5A50001);
        run(32'h100, 4, 32'hA5A50000, -1, 0, 32'h108, -10, -1, 10, 1, 32'h108, 0, 2, 32'h104, 32'hA5A50000);
        run(32'h100, 4, 32'hA5A50000, -1, 0, 32'h1, 3, -1, 5, 0, 32'h0, 0, 3, 32'h108, 32'hA5A50001);
        run(32'h100, 0, 32'hA5A50000, -1, 0, 32'h1, -10, -1, 1, 0, 32'h0, 1, -1, 32'h0, 32'h0);
        @(negedge HCLK);
        base_addr = 32'h200; num_words = 8; seed = 32'h1234; start = 1;
        @(posedge HCLK);
        #1 start = 0;
        repeat (3) @(posedge HCLK);
        #1 chk("mid-run busy before reset", 32'(busy), 1, -1);
        #1 HRESETn = 0;
        #1 reset_outputs("mid-run reset");
        @(negedge HCLK);
        HRESETn = 1;
        repeat (5) begin
            @(posedge HCLK);
            #1 chk("post-reset htrans", 32'(HTRANS), 0, -1);
            chk("post-reset busy", 32'(busy), 0, -1);
        end
        run(32'hFFFFFFFE, 2, 32'hFFFFFFFF, -1, 0, 32'h1, -10, -1, 6, 0, 32'h0, 1, 2, 32'h0, 32'hFFFFFFFF);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
